alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback_pkg.sv | 35 +++
 rtl/alu_writeback_fifo.sv | 59 +++++
 rtl/alu_writeback.sv | 82 ++++++++
 tb/tb_alu_writeback.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_writeback_pkg.sv
// alu_writeback shared types and constants.
// Instruction kinds, overflow status codes, buffer entry.
package alu_writeback_pkg;

  localparam logic [1:0] KIND_ADD   = 2'd0;
  localparam logic [1:0] KIND_ADDI  = 2'd1;
  localparam logic [1:0] KIND_SUB   = 2'd2;
  localparam logic [1:0] KIND_OTHER = 2'd3;

  localparam logic [31:0] STATUS_ADD  = 32'd1;
  localparam logic [31:0] STATUS_ADDI = 32'd2;
  localparam logic [31:0] STATUS_SUB  = 32'd3;

  localparam int STATUS_REG_DEF = 30;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [31:0] status_code(
    input logic [1:0] kind
  );
    logic [31:0] code;
    code = '0;
    unique case (1'b1)
      (kind == KIND_ADD):  code = STATUS_ADD;
      (kind == KIND_ADDI): code = STATUS_ADDI;
      (kind == KIND_SUB):  code = STATUS_SUB;
      default:             code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_writeback_fifo.sv
// wb_fifo2: two-entry writeback buffer.
// Wrap-around pointers; head reads as zero when empty.
module wb_fifo2
  import alu_writeback_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic [1:0] occupancy
);

  wb_entry_t  mem_q [2];
  wb_entry_t  mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push_ok, pop_ok;

  // next-state for storage, pointers and count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push_ok  = push && (cnt_q != 2'd2);
    pop_ok   = pop && (cnt_q != 2'd0);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head      = (cnt_q == 2'd0) ? '0 : mem_q[rd_ptr_q];
  assign occupancy = cnt_q;

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: buffers ALU results for the register file.
// Overflows become status writes to STATUS_REG.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int STATUS_REG = STATUS_REG_DEF,
  parameter int DEPTH      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic        in_we,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic        in_overflow,
  input  logic        rf_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [1:0]  occupancy,
  output logic [7:0]  exc_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  wb_entry_t  push_entry;
  wb_entry_t  head;
  logic [1:0] occ;
  logic       accept, exc, store, push, pop;
  logic [7:0] exc_count_q, exc_count_d;

  // classify the offered op and build the entry to store
  always_comb begin
    accept     = in_valid && in_ready;
    exc        = in_overflow && (in_kind != KIND_OTHER);
    store      = exc || (in_we && (in_rd != 5'd0));
    push       = accept && store;
    push_entry = '{rd: in_rd, data: in_result};
    if (exc) begin
      push_entry = '{rd: 5'(STATUS_REG),
                     data: status_code(in_kind)};
    end
  end

  // saturating exception counter next value
  always_comb begin
    exc_count_d = exc_count_q;
    if (accept && exc && (exc_count_q != 8'hff)) begin
      exc_count_d = exc_count_q + 8'd1;
    end
  end

  // exception counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exc_count_q <= 8'd0;
    end else begin
      exc_count_q <= exc_count_d;
    end
  end

  wb_fifo2 u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .occupancy (occ)
  );

  assign in_ready         = (occ != FULL);
  assign pop              = (occ != 2'd0) && rf_ready;
  assign ctrl_writeEnable = pop;
  assign ctrl_writeReg    = head.rd;
  assign data_writeReg    = head.data;
  assign occupancy        = occ;
  assign exc_count        = exc_count_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: queue model plus directed and random ops.
// Compares all outputs on every falling edge.
module tb_alu_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind = 2'd0;
  logic        in_we = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_result = 32'd0;
  logic        in_overflow = 1'b0;
  logic        rf_ready = 1'b1;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [1:0]  occupancy;
  logic [7:0]  exc_count;

  int total = 0;
  int bad   = 0;

  alu_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_kind          (in_kind),
    .in_we            (in_we),
    .in_rd            (in_rd),
    .in_result        (in_result),
    .in_overflow      (in_overflow),
    .rf_ready         (rf_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .occupancy        (occupancy),
    .exc_count        (exc_count)
  );

  always #5 clock = ~clock;

  // reference model: FIFO of pending writes
  int          m_rd [$];
  logic [31:0] m_dat [$];
  int          m_exc = 0;
  bit          m_rdy, m_wen;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_rd.delete();
      m_dat.delete();
      m_exc = 0;
    end else begin
      m_rdy = (m_rd.size() < 2);
      m_wen = (m_rd.size() > 0) && rf_ready;
      if (m_wen) begin
        void'(m_rd.pop_front());
        void'(m_dat.pop_front());
      end
      if (in_valid && m_rdy) begin
        if (in_overflow && in_kind != 2'd3) begin
          m_rd.push_back(30);
          m_dat.push_back(32'(in_kind) + 32'd1);
          if (m_exc < 255) m_exc++;
        end else if (in_we && in_rd != 0) begin
          m_rd.push_back(int'(in_rd));
          m_dat.push_back(in_result);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clock) begin
    int n;
    n = m_rd.size();
    chk("m_ready", 32'(in_ready), 32'(n < 2));
    chk("m_wen", 32'(ctrl_writeEnable),
        32'(n > 0 && rf_ready));
    chk("m_reg", 32'(ctrl_writeReg),
        n > 0 ? 32'(m_rd[0]) : 32'd0);
    chk("m_data", data_writeReg,
        n > 0 ? m_dat[0] : 32'd0);
    chk("m_occ", 32'(occupancy), 32'(n));
    chk("m_exc", 32'(exc_count), 32'(m_exc));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic [1:0] k,
                    input logic we,
                    input logic [4:0] rd,
                    input logic [31:0] res,
                    input logic ovf);
    in_valid    = 1'b1;
    in_kind     = k;
    in_we       = we;
    in_rd       = rd;
    in_result   = res;
    in_overflow = ovf;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wen", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_exc", 32'(exc_count), 32'd0);
    #2;
    reset = 1'b1;
    // add rd5, accepted on first edge after release
    op(2'd0, 1'b1, 5'd5, 32'h12345678, 1'b0);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    chk("add_wen", 32'(ctrl_writeEnable), 32'd1);
    chk("add_reg", 32'(ctrl_writeReg), 32'd5);
    chk("add_data", data_writeReg, 32'h12345678);
    cyc();
    @(negedge clock);
    chk("add_occ", 32'(occupancy), 32'd0);
    chk("add_wen0", 32'(ctrl_writeEnable), 32'd0);
    cyc();
    // sub overflow -> status write
    op(2'd2, 1'b1, 5'd7, 32'hdeadbeef, 1'b1);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    chk("sub_reg", 32'(ctrl_writeReg), 32'd30);
    chk("sub_data", data_writeReg, 32'd3);
    chk("sub_exc", 32'(exc_count), 32'd1);
    cyc();
    // other kind ignores overflow
    op(2'd3, 1'b1, 5'd7, 32'h0000cafe, 1'b1);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    chk("oth_reg", 32'(ctrl_writeReg), 32'd7);
    chk("oth_data", data_writeReg, 32'h0000cafe);
    chk("oth_exc", 32'(exc_count), 32'd1);
    cyc();
    // backpressure: 1,2 buffered, 3 stalls
    rf_ready = 1'b0;
    op(2'd0, 1'b1, 5'd1, 32'h111, 1'b0);
    cyc();
    op(2'd0, 1'b1, 5'd2, 32'h222, 1'b0);
    cyc();
    op(2'd0, 1'b1, 5'd3, 32'h333, 1'b0);
    @(negedge clock);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_occ", 32'(occupancy), 32'd2);
    #1;
    rf_ready = 1'b1;
    #1;
    chk("bp_w1", 32'(ctrl_writeReg), 32'd1);
    chk("bp_w1en", 32'(ctrl_writeEnable), 32'd1);
    cyc();
    @(negedge clock);
    chk("bp_w2", 32'(ctrl_writeReg), 32'd2);
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_w3", 32'(ctrl_writeReg), 32'd3);
    chk("bp_w3d", data_writeReg, 32'h333);
    chk("bp_occ1", 32'(occupancy), 32'd1);
    cyc();
    // rd0 is dropped; rd0 with addi overflow is not
    op(2'd0, 1'b1, 5'd0, 32'h55, 1'b0);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    chk("rd0_occ", 32'(occupancy), 32'd0);
    chk("rd0_wen", 32'(ctrl_writeEnable), 32'd0);
    op(2'd1, 1'b1, 5'd0, 32'h55, 1'b1);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    chk("addi_reg", 32'(ctrl_writeReg), 32'd30);
    chk("addi_data", data_writeReg, 32'd2);
    cyc();
    // reset discards buffered entries
    rf_ready = 1'b0;
    op(2'd0, 1'b1, 5'd9, 32'h99, 1'b0);
    cyc();
    op(2'd0, 1'b1, 5'd10, 32'haa, 1'b0);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    chk("mr_occ2", 32'(occupancy), 32'd2);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_occ", 32'(occupancy), 32'd0);
    chk("mr_reg", 32'(ctrl_writeReg), 32'd0);
    chk("mr_data", data_writeReg, 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd1);
    #2;
    reset = 1'b1;
    rf_ready = 1'b1;
    @(negedge clock);
    chk("mr_nowen", 32'(ctrl_writeEnable), 32'd0);
    cyc();
    // exception counter saturation
    for (int i = 0; i < 300; i++) begin
      op(2'd2, 1'b0, 5'($urandom_range(0, 31)),
         $urandom, 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("sat_exc", 32'(exc_count), 32'd255);
    cyc();
    cyc();
    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_kind     = 2'($urandom_range(0, 3));
      in_we       = ($urandom_range(0, 4) != 0);
      in_rd       = ($urandom_range(0, 5) == 0) ? 5'd0
                    : 5'($urandom_range(1, 31));
      in_result   = $urandom;
      in_overflow = ($urandom_range(0, 3) == 0);
      rf_ready    = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      cyc();
    end
    in_valid = 1'b0;
    rf_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
